ovc_class_allocator: RTL and testbench



---
 rtl/ovc_class_allocator_pkg.sv | 50 +++++
 rtl/ovc_prio_rr_pick.sv | 38 +++
 rtl/ovc_class_allocator.sv | 128 ++++++++++++
 tb/tb_ovc_class_allocator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ovc_class_allocator_pkg.sv
// Shared sizing helpers and the destination-port to VC-preference mapping
// used by the output-VC class allocator.
package ovc_class_allocator_pkg;

    localparam int V_DEF = 4;
    localparam int C_DEF = 2;
    localparam int P_DEF = 5;

    // Class index width; never narrower than one bit so ports stay legal.
    function automatic int class_w(input int c);
        return (c <= 2) ? 1 : $clog2(c);
    endfunction

    function automatic int cv_w(input int c, input int v);
        return c * v;
    endfunction

    function automatic int ptr_w(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    // Maps a one-hot destination port of width pw onto a v-bit VC preference.
    function automatic logic [31:0] dest_to_pri(input int v, input int pw,
                                                input logic [31:0] dest);
        logic [31:0] pri;
        logic [31:0] keep;
        int          grp;
        pri  = '0;
        grp  = 1;
        keep = (v >= 32) ? '1 : ((32'd1 << v) - 32'd1);
        if (pw == v) begin
            pri = dest;
        end else if (pw > v) begin
            grp = (pw + v - 1) / v;
            for (int i = 0; i < 32; i++) begin
                if (i < pw && dest[i]) begin
                    pri[i / grp] = 1'b1;
                end
            end
        end else begin
            pri = dest << (v / pw);
        end
        pri = pri & keep;
        if (pri == '0) begin
            pri = 32'd1;
        end
        return pri;
    endfunction

endpackage

// File: rtl/ovc_prio_rr_pick.sv
// Combinational round-robin picker: prefers the priority subset of the mask
// when non-empty, otherwise searches the whole mask starting at ptr.
module ovc_prio_rr_pick
    import ovc_class_allocator_pkg::*;
#(
    parameter int V = V_DEF,
    localparam int PW = ptr_w(V)
) (
    input  logic [V-1:0]  mask,
    input  logic [V-1:0]  pri,
    input  logic [PW-1:0] ptr,
    output logic [V-1:0]  pick,
    output logic          pick_valid
);

    logic [V-1:0] pref;
    logic [V-1:0] pick_set;
    logic         found;
    int           idx;

    assign pref       = mask & pri;
    assign pick_set   = (|pref) ? pref : mask;
    assign pick_valid = |pick_set;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < V; i++) begin
            idx = (int'(ptr) + i) % V;
            if (!found && pick_set[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ovc_class_allocator.sv
// Per-output-port VC allocator: programmable class-to-VC table, busy
// tracking and per-class round-robin grant with optional dest-port preference.
module ovc_class_allocator
    import ovc_class_allocator_pkg::*;
#(
    parameter int              V             = V_DEF,
    parameter int              C             = C_DEF,
    parameter int              P             = P_DEF,
    parameter logic [C*V-1:0]  CLASS_SETTING = {C*V{1'b1}},
    parameter bit              DEST_PRIO_EN  = 1'b1,
    localparam int             CW            = class_w(C),
    localparam int             CVW           = cv_w(C, V),
    localparam int             PW            = ptr_w(V)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_wr,
    input  logic [CW-1:0] cfg_class,
    input  logic [V-1:0]  cfg_mask,
    output logic          cfg_err,
    input  logic          req,
    input  logic [CW-1:0] req_class,
    input  logic [P-2:0]  req_dest,
    output logic          grant_valid,
    output logic [V-1:0]  grant_ovc,
    output logic          req_stall,
    output logic          req_err,
    input  logic [V-1:0]  ovc_release,
    output logic [V-1:0]  ovc_busy,
    output logic [V-1:0]  class_mask
);

    logic [CVW-1:0] table_q;
    logic [V-1:0]   busy_q;
    logic [PW-1:0]  ptr_q [C];

    logic           cls_ok;
    int             cls_sel;
    logic [PW-1:0]  ptr_cur;
    logic [V-1:0]   eligible;
    logic [V-1:0]   pri;
    logic [V-1:0]   pick;
    logic           pick_valid;
    logic           do_grant;
    logic [PW-1:0]  ptr_next;
    int             pick_idx;
    logic           cfg_ok;

    // With class masking disabled every request maps onto class 0 state.
    assign cls_sel = (C <= 1) ? 0 : int'(req_class);
    assign cls_ok  = (C <= 1) || (int'(req_class) < C);
    assign cfg_ok  = cfg_wr && (cfg_mask != '0) && (int'(cfg_class) < C);

    always_comb begin
        class_mask = '0;
        ptr_cur    = '0;
        if (C <= 1) begin
            class_mask = '1;
        end
        for (int c = 0; c < C; c++) begin
            if (cls_sel == c) begin
                if (C > 1) begin
                    class_mask = table_q[c*V +: V];
                end
                ptr_cur = ptr_q[c];
            end
        end
    end

    assign eligible = class_mask & ~busy_q;
    assign pri      = DEST_PRIO_EN ? V'(dest_to_pri(V, P - 1, 32'(req_dest))) : '0;

    ovc_prio_rr_pick #(
        .V (V)
    ) u_pick (
        .mask       (eligible),
        .pri        (pri),
        .ptr        (ptr_cur),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    assign do_grant = req && cls_ok && pick_valid;

    always_comb begin
        pick_idx = 0;
        for (int k = 0; k < V; k++) begin
            if (pick[k]) begin
                pick_idx = k;
            end
        end
        ptr_next = (pick_idx == V - 1) ? '0 : PW'(pick_idx + 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            table_q     <= CLASS_SETTING;
            busy_q      <= '0;
            for (int c = 0; c < C; c++) begin
                ptr_q[c] <= '0;
            end
            grant_valid <= 1'b0;
            grant_ovc   <= '0;
            req_stall   <= 1'b0;
            req_err     <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            for (int c = 0; c < C; c++) begin
                if (cfg_ok && int'(cfg_class) == c) begin
                    table_q[c*V +: V] <= cfg_mask;
                end
                if (do_grant && cls_sel == c) begin
                    ptr_q[c] <= ptr_next;
                end
            end
            // A granted VC is never busy this cycle, so set-after-clear is safe.
            busy_q      <= (busy_q & ~ovc_release) | (do_grant ? pick : '0);
            grant_valid <= do_grant;
            grant_ovc   <= do_grant ? pick : '0;
            req_stall   <= req && cls_ok && !pick_valid;
            req_err     <= req && !cls_ok;
            cfg_err     <= cfg_wr && !cfg_ok;
        end
    end

    assign ovc_busy = busy_q;

endmodule

// File: tb/tb_ovc_class_allocator.sv
// Directed-vector bench for ovc_class_allocator: main C=2 build, a C=1 build
// and a C=3 build for out-of-range class handling.
module tb_ovc_class_allocator;

    logic clk;
    logic reset;

    int n_checks;
    int n_errs;

    logic       a_cfg_wr, a_cfg_err, a_req, a_gv, a_stall, a_rerr;
    logic [0:0] a_cfg_class, a_req_class;
    logic [3:0] a_cfg_mask, a_req_dest, a_grant, a_rel, a_busy, a_cmask;

    logic       b_cfg_wr, b_cfg_err, b_req, b_gv, b_stall, b_rerr;
    logic [0:0] b_cfg_class, b_req_class;
    logic [3:0] b_cfg_mask, b_req_dest, b_grant, b_rel, b_busy, b_cmask;

    logic       c_cfg_wr, c_cfg_err, c_req, c_gv, c_stall, c_rerr;
    logic [1:0] c_cfg_class, c_req_class;
    logic [3:0] c_cfg_mask, c_req_dest, c_grant, c_rel, c_busy, c_cmask;

    ovc_class_allocator #(
        .V (4), .C (2), .P (5), .CLASS_SETTING (8'b1100_0011), .DEST_PRIO_EN (1'b1)
    ) dut_a (
        .clk (clk), .reset (reset),
        .cfg_wr (a_cfg_wr), .cfg_class (a_cfg_class), .cfg_mask (a_cfg_mask), .cfg_err (a_cfg_err),
        .req (a_req), .req_class (a_req_class), .req_dest (a_req_dest),
        .grant_valid (a_gv), .grant_ovc (a_grant), .req_stall (a_stall), .req_err (a_rerr),
        .ovc_release (a_rel), .ovc_busy (a_busy), .class_mask (a_cmask)
    );

    ovc_class_allocator #(
        .V (4), .C (1), .P (5), .CLASS_SETTING (4'b1111), .DEST_PRIO_EN (1'b0)
    ) dut_b (
        .clk (clk), .reset (reset),
        .cfg_wr (b_cfg_wr), .cfg_class (b_cfg_class), .cfg_mask (b_cfg_mask), .cfg_err (b_cfg_err),
        .req (b_req), .req_class (b_req_class), .req_dest (b_req_dest),
        .grant_valid (b_gv), .grant_ovc (b_grant), .req_stall (b_stall), .req_err (b_rerr),
        .ovc_release (b_rel), .ovc_busy (b_busy), .class_mask (b_cmask)
    );

    ovc_class_allocator #(
        .V (4), .C (3), .P (5), .CLASS_SETTING (12'b1111_1100_0011), .DEST_PRIO_EN (1'b1)
    ) dut_c (
        .clk (clk), .reset (reset),
        .cfg_wr (c_cfg_wr), .cfg_class (c_cfg_class), .cfg_mask (c_cfg_mask), .cfg_err (c_cfg_err),
        .req (c_req), .req_class (c_req_class), .req_dest (c_req_dest),
        .grant_valid (c_gv), .grant_ovc (c_grant), .req_stall (c_stall), .req_err (c_rerr),
        .ovc_release (c_rel), .ovc_busy (c_busy), .class_mask (c_cmask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_req_set(input logic on, input logic [0:0] cls, input logic [3:0] dest);
        a_req       = on;
        a_req_class = cls;
        a_req_dest  = dest;
    endtask

    task automatic a_release(input logic [3:0] r);
        a_req_set(1'b0, 1'b0, 4'b0001);
        a_rel = r;
        step();
        a_rel = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errs   = 0;
        reset    = 1'b1;
        {a_cfg_wr, a_cfg_class, a_cfg_mask, a_req, a_req_class, a_req_dest, a_rel} = '0;
        {b_cfg_wr, b_cfg_class, b_cfg_mask, b_req, b_req_class, b_req_dest, b_rel} = '0;
        {c_cfg_wr, c_cfg_class, c_cfg_mask, c_req, c_req_class, c_req_dest, c_rel} = '0;
        step();
        step();
        reset = 1'b0;

        chk("rst_busy",  32'(a_busy),  0);
        chk("rst_gv",    32'(a_gv),    0);
        chk("rst_grant", 32'(a_grant), 0);
        chk("rst_stall", 32'(a_stall), 0);
        chk("rst_cfgerr", 32'(a_cfg_err), 0);

        // class 0: first grant, second grant, then stall
        a_req_set(1'b1, 1'b0, 4'b0001);
        step();
        chk("c0_g1_valid", 32'(a_gv),    1);
        chk("c0_g1_ovc",   32'(a_grant), 32'b0001);
        chk("c0_g1_busy",  32'(a_busy),  32'b0001);
        step();
        chk("c0_g2_ovc",   32'(a_grant), 32'b0010);
        chk("c0_g2_busy",  32'(a_busy),  32'b0011);
        step();
        chk("c0_stall",    32'(a_stall), 1);
        chk("c0_stall_gv", 32'(a_gv),    0);
        chk("c0_stall_ovc", 32'(a_grant), 0);
        a_release(4'b0001);
        chk("c0_rel_busy", 32'(a_busy), 32'b0010);
        step();
        a_req_set(1'b1, 1'b0, 4'b0001);
        step();
        chk("c0_regrant", 32'(a_grant), 32'b0001);
        a_release(4'b0011);
        chk("c0_rel_all", 32'(a_busy), 0);

        // ptr0 is 1, but dest preference steers the pick to VC0
        a_req_set(1'b1, 1'b0, 4'b0001);
        step();
        chk("c0_prio", 32'(a_grant), 32'b0001);
        a_release(4'b0001);

        // class 1: dest pref misses the class mask, RR 0100 then 1000, wrap
        a_req_set(1'b1, 1'b1, 4'b0001);
        step();
        chk("c1_g1", 32'(a_grant), 32'b0100);
        step();
        chk("c1_g2", 32'(a_grant), 32'b1000);
        a_release(4'b1100);
        a_req_set(1'b1, 1'b1, 4'b0001);
        step();
        chk("c1_wrap", 32'(a_grant), 32'b0100);
        a_release(4'b0100);

        // config: zero mask rejected
        a_cfg_wr = 1'b1; a_cfg_class = 1'b1; a_cfg_mask = 4'b0000;
        step();
        a_cfg_wr = 1'b0;
        chk("cfg_zero_err", 32'(a_cfg_err), 1);
        a_req_class = 1'b1;
        #1;
        chk("cfg_zero_keep", 32'(a_cmask), 32'b1100);
        step();
        chk("cfg_err_clear", 32'(a_cfg_err), 0);

        // write and req in the same cycle: req sees the old mask (ptr1=3)
        a_cfg_wr = 1'b1; a_cfg_class = 1'b1; a_cfg_mask = 4'b0010;
        a_req_set(1'b1, 1'b1, 4'b0001);
        step();
        a_cfg_wr = 1'b0;
        chk("cfg_same_cyc", 32'(a_grant), 32'b1000);
        chk("cfg_ok_noerr", 32'(a_cfg_err), 0);
        a_release(4'b1000);
        a_req_class = 1'b1;
        #1;
        chk("cfg_new_mask", 32'(a_cmask), 32'b0010);
        a_req_set(1'b1, 1'b1, 4'b0001);
        step();
        chk("cfg_new_grant", 32'(a_grant), 32'b0010);
        a_release(4'b0010);

        // fill all VCs through class 0, then reset with a request pending
        a_cfg_wr = 1'b1; a_cfg_class = 1'b0; a_cfg_mask = 4'b1111;
        step();
        a_cfg_wr = 1'b0;
        a_req_set(1'b1, 1'b0, 4'b0001);
        for (int i = 0; i < 4; i++) step();
        chk("fill_busy", 32'(a_busy), 32'b1111);
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_req = 1'b0;
        chk("mid_rst_busy", 32'(a_busy), 0);
        chk("mid_rst_gv",   32'(a_gv),   0);
        a_req_class = 1'b1;
        #1;
        chk("mid_rst_tbl1", 32'(a_cmask), 32'b1100);
        a_req_class = 1'b0;
        #1;
        chk("mid_rst_tbl0", 32'(a_cmask), 32'b0011);

        // C=1 build: masking disabled, class index ignored
        b_req = 1'b1; b_req_class = 1'b1; b_req_dest = 4'b1000;
        #1;
        chk("c1b_mask", 32'(b_cmask), 32'b1111);
        step();
        chk("c1b_g1",   32'(b_grant), 32'b0001);
        chk("c1b_noerr", 32'(b_rerr), 0);
        step();
        chk("c1b_g2",   32'(b_grant), 32'b0010);
        b_req = 1'b0;

        // C=3 build: out-of-range class on request and config
        c_req = 1'b1; c_req_class = 2'd3; c_req_dest = 4'b0001;
        c_cfg_wr = 1'b1; c_cfg_class = 2'd3; c_cfg_mask = 4'b0001;
        step();
        c_cfg_wr = 1'b0;
        chk("c3_req_err", 32'(c_rerr),    1);
        chk("c3_no_gv",   32'(c_gv),      0);
        chk("c3_cfg_err", 32'(c_cfg_err), 1);
        c_req_class = 2'd2; c_req_dest = 4'b0100;
        step();
        c_req = 1'b0;
        chk("c3_cls2_prio", 32'(c_grant), 32'b0100);
        chk("c3_err_clear", 32'(c_rerr),  0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
